// File: rtl/mem_init_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_init_pkg
// Brief  : Shared types and constants for the table init sequencer:
//          FSM state encoding, per-channel fill mode codes and the LFSR
//          polynomial plus its single-step helper.
// Rev    : 1.0  initial release
// ============================================================================
package mem_init_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ZERO  = 2'b00;
    localparam logic [1:0] MODE_INDEX = 2'b01;
    localparam logic [1:0] MODE_CONST = 2'b10;
    localparam logic [1:0] MODE_LFSR  = 2'b11;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_init_lfsr.sv
`default_nettype none
// ============================================================================
// Module : mem_init_lfsr
// Brief  : 32-bit Galois LFSR shared by all LFSR-mode channels. Reloads the
//          seed on load, steps once on adv. Only built when INIT_LFSR_EN is
//          defined.
// Rev    : 1.0  initial release
// ============================================================================
module mem_init_lfsr
    import mem_init_pkg::*;
(
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        load,
    input  logic        adv,
    input  logic [31:0] seed,
    output logic [31:0] q
);

    // Seed on reset or load, otherwise advance once per accepted write.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            q <= seed;
        end else if (load) begin
            q <= seed;
        end else if (adv) begin
            q <= lfsr_step(q);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module : mem_init_sequencer
// Brief  : Multi-channel boot/re-init sequencer. One address counter sweeps
//          0..DEPTH-1 and drives per-channel write strobes and fill data,
//          throttled by wr_ready_i. Optional macro INIT_LFSR_EN builds the
//          LFSR fill mode; without it mode 11 fills zeros.
// Rev    : 1.0  initial release
// ============================================================================
module mem_init_sequencer
    import mem_init_pkg::*;
#(
    parameter int                NUM_CH     = 3,
    parameter int                DATA_W     = 40,
    parameter int                ADDR_W     = 8,
    parameter int                DEPTH      = 256,
    parameter logic [DATA_W-1:0] FILL_CONST = '0,
    parameter int                AUTO_START = 1,
    parameter logic [31:0]       LFSR_SEED  = 32'hACE1_0001
) (
    input  logic                     clk,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [NUM_CH-1:0]        ch_en_i,
    input  logic [2*NUM_CH-1:0]      ch_mode_i,
    input  logic                     wr_ready_i,
    output logic [NUM_CH-1:0]        init_we_o,
    output logic [ADDR_W-1:0]        init_addr_o,
    output logic [NUM_CH*DATA_W-1:0] init_data_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int IW = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

    // Elaboration-time configuration sanity checks.
    if (DEPTH > (64'd1 << ADDR_W) || DEPTH < 2) begin : g_depth_err
        $error("mem_init_sequencer: DEPTH must be in 2..2**ADDR_W");
    end
    if (LFSR_SEED == 32'd0) begin : g_seed_err
        $error("mem_init_sequencer: LFSR_SEED must be nonzero");
    end

    state_t                  state;
    logic                    auto_pend;
    logic [2*NUM_CH-1:0]     mode_q;

    logic                    enter;
    logic                    accept;
    logic                    last;
    logic [ADDR_W-1:0]       nxt_addr;
    logic [2*NUM_CH-1:0]     sel_mode;
    logic [IW-1:0]           idx_ext;
    logic [NUM_CH*DATA_W-1:0] fill_vec;

    // A pass starts from IDLE on start or a pending auto-start, from DONE on start only.
    assign enter    = ((state == ST_IDLE) && (start_i || auto_pend)) ||
                      ((state == ST_DONE) && start_i);
    // The sweep is timed by ready alone, so an all-zero mask still walks the table.
    assign accept   = (state == ST_FILL) && wr_ready_i;
    assign last     = (init_addr_o == ADDR_W'(DEPTH - 1));
    assign nxt_addr = enter ? '0 : (init_addr_o + ADDR_W'(1));
    assign sel_mode = enter ? ch_mode_i : mode_q;
    assign idx_ext  = IW'(nxt_addr);

`ifdef INIT_LFSR_EN
    localparam int REP = (DATA_W + 31) / 32;

    logic [31:0]      lfsr_q;
    logic [31:0]      nxt_lfsr;
    logic [REP*32-1:0] lfsr_rep;

    mem_init_lfsr u_lfsr (
        .clk    (clk),
        .rst_ni (rst_ni),
        .load   (enter),
        .adv    (accept),
        .seed   (LFSR_SEED),
        .q      (lfsr_q)
    );

    // Data is registered, so it is built from the LFSR value the next entry will see.
    assign nxt_lfsr = enter ? LFSR_SEED : lfsr_step(lfsr_q);
    assign lfsr_rep = {REP{nxt_lfsr}};
`endif

    // Per-channel fill mux, evaluated for the address about to be presented.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DATA_W-1:0] val;

        // Select fill value for channel k from its mode.
        always_comb begin
            val = '0;
            case (sel_mode[2*k +: 2])
                MODE_ZERO:  val = '0;
                MODE_INDEX: val = idx_ext[DATA_W-1:0];
                MODE_CONST: val = FILL_CONST;
`ifdef INIT_LFSR_EN
                MODE_LFSR:  val = lfsr_rep[DATA_W-1:0];
`else
                MODE_LFSR:  val = '0;
`endif
                default:    val = '0;
            endcase
        end

        assign fill_vec[k*DATA_W +: DATA_W] = val;
    end

    // Sequencer FSM with registered strobes, address, data and status.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            auto_pend   <= (AUTO_START != 0);
            mode_q      <= '0;
            init_we_o   <= '0;
            init_addr_o <= '0;
            init_data_o <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (enter) begin
                        state       <= ST_FILL;
                        auto_pend   <= 1'b0;
                        mode_q      <= ch_mode_i;
                        init_we_o   <= ch_en_i;
                        init_addr_o <= nxt_addr;
                        init_data_o <= fill_vec;
                        busy_o      <= 1'b1;
                        done_o      <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        if (last) begin
                            state     <= ST_DONE;
                            init_we_o <= '0;
                            busy_o    <= 1'b0;
                            done_o    <= 1'b1;
                        end else begin
                            init_addr_o <= nxt_addr;
                            init_data_o <= fill_vec;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_init_sequencer
// Brief  : Self-checking bench for mem_init_sequencer. Instance A: 3 x 40-bit,
//          DEPTH 256, auto-start. Instance B: 3 x 4-bit, DEPTH 32, start-only.
//          Expected writes come from a transaction-level model: the n-th
//          accepted write of a pass goes to address n with data from the mode.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_init_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_a, start_a, rdy_a, busy_a, done_a;
    logic [2:0]   en_a, we_a;
    logic [5:0]   mode_a;
    logic [7:0]   addr_a;
    logic [119:0] data_a;

    logic         rst_b, start_b, rdy_b, busy_b, done_b;
    logic [2:0]   en_b, we_b;
    logic [5:0]   mode_b;
    logic [7:0]   addr_b;
    logic [11:0]  data_b;

    mem_init_sequencer #(
        .NUM_CH(3), .DATA_W(40), .ADDR_W(8), .DEPTH(256),
        .FILL_CONST(40'h5A), .AUTO_START(1), .LFSR_SEED(32'hACE1_0001)
    ) dut_a (
        .clk(clk), .rst_ni(rst_a), .start_i(start_a), .ch_en_i(en_a),
        .ch_mode_i(mode_a), .wr_ready_i(rdy_a), .init_we_o(we_a),
        .init_addr_o(addr_a), .init_data_o(data_a), .busy_o(busy_a), .done_o(done_a)
    );

    mem_init_sequencer #(
        .NUM_CH(3), .DATA_W(4), .ADDR_W(8), .DEPTH(32),
        .FILL_CONST(4'h9), .AUTO_START(0), .LFSR_SEED(32'hACE1_0001)
    ) dut_b (
        .clk(clk), .rst_ni(rst_b), .start_i(start_b), .ch_en_i(en_b),
        .ch_mode_i(mode_b), .wr_ready_i(rdy_b), .init_we_o(we_b),
        .init_addr_o(addr_b), .init_data_o(data_b), .busy_o(busy_b), .done_o(done_b)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] lfsr_at [0:256];

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Fill value of one channel for the idx-th write of a pass.
    function automatic logic [63:0] fill_ref(input int dw, input logic [1:0] mode,
                                             input int idx, input logic [63:0] cval);
        logic [63:0] m;
        m = (64'd1 << dw) - 64'd1;
        case (mode)
            2'd1: return 64'(idx) & m;
            2'd2: return cval & m;
            2'd3: begin
`ifdef INIT_LFSR_EN
                return {lfsr_at[idx], lfsr_at[idx]} & m;
`else
                return 64'd0;
`endif
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [127:0] bus_ref(input int dw, input logic [5:0] modes,
                                             input int idx, input logic [63:0] cval);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 3; k++)
            r = r | (128'(fill_ref(dw, modes[2*k +: 2], idx, cval)) << (k * dw));
        return r;
    endfunction

    // Follows one pass from its first strobe cycle to DONE, checking every cycle.
    task automatic sweep(input bit which, input logic [2:0] mask, input logic [5:0] modes,
                         input int prob, input int stall_at, input int stall_len,
                         input int start_at, input int rst_at, output int cyc);
        int dep, dw, idx, stall_left;
        bit rdy, did_rst;
        logic [63:0]  cv;
        logic [2:0]   o_we;
        logic [7:0]   o_addr;
        logic [127:0] o_data;
        logic         o_busy, o_done;
        dep = which ? 32 : 256;
        dw  = which ? 4 : 40;
        cv  = which ? 64'h9 : 64'h5A;
        idx = 0; cyc = 0; stall_left = stall_len; did_rst = 1'b0;
        while (idx < dep && cyc < 4000) begin
            o_we   = which ? we_b : we_a;
            o_addr = which ? addr_b : addr_a;
            o_data = which ? 128'(data_b) : 128'(data_a);
            o_busy = which ? busy_b : busy_a;
            check_value("we", 128'(o_we), 128'(mask));
            check_value("addr", 128'(o_addr), 128'(idx));
            check_value("data", o_data, bus_ref(dw, modes, idx, cv));
            check_value("busy", 128'(o_busy), 128'd1);
            if (!which && idx == rst_at && !did_rst) begin
                rst_a = 1'b0; en_a = mask; mode_a = modes; rdy_a = 1'b1;
                @(posedge clk); #1;
                check_value("rst_we", 128'(we_a), 128'd0);
                check_value("rst_addr", 128'(addr_a), 128'd0);
                check_value("rst_data", 128'(data_a), 128'd0);
                check_value("rst_busy", 128'(busy_a), 128'd0);
                check_value("rst_done", 128'(done_a), 128'd0);
                rst_a = 1'b1;
                @(posedge clk); #1;
                idx = 0; did_rst = 1'b1; cyc++;
                continue;
            end
            rdy = ($urandom_range(99) < prob);
            if (idx == stall_at && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end
            if (which) begin
                rdy_b = rdy; start_b = (idx == start_at);
                if (start_b) rdy_b = 1'b1;
                en_b = 3'($urandom); mode_b = 6'($urandom);
                rdy = rdy_b;
            end else begin
                rdy_a = rdy; start_a = (idx == start_at);
                if (start_a) rdy_a = 1'b1;
                en_a = 3'($urandom); mode_a = 6'($urandom);
                rdy = rdy_a;
            end
            @(posedge clk); #1;
            start_a = 1'b0; start_b = 1'b0;
            if (rdy) idx++;
            cyc++;
        end
        check_value("sweep_len", 128'(idx), 128'(dep));
        o_we   = which ? we_b : we_a;
        o_busy = which ? busy_b : busy_a;
        o_done = which ? done_b : done_a;
        check_value("end_we", 128'(o_we), 128'd0);
        check_value("end_busy", 128'(o_busy), 128'd0);
        check_value("end_done", 128'(o_done), 128'd1);
    endtask

    initial begin
        int c;
        logic [2:0] m;
        logic [5:0] md;

        lfsr_at[0] = 32'hACE1_0001;
        for (int k = 0; k < 256; k++)
            lfsr_at[k+1] = (lfsr_at[k] >> 1) ^ ({32{lfsr_at[k][0]}} & 32'h8020_0003);

        rst_a = 1'b0; start_a = 1'b0; rdy_a = 1'b0; en_a = 3'b111; mode_a = {2'b10, 2'b01, 2'b00};
        rst_b = 1'b0; start_b = 1'b0; rdy_b = 1'b0; en_b = 3'b010; mode_b = 6'b01_01_01;
        repeat (3) @(posedge clk);
        #1;
        check_value("reset_we", 128'({we_a, we_b}), 128'd0);
        check_value("reset_addr", 128'({addr_a, addr_b}), 128'd0);
        check_value("reset_data", 128'(data_a) | 128'(data_b), 128'd0);
        check_value("reset_busy", 128'({busy_a, busy_b}), 128'd0);
        check_value("reset_done", 128'({done_a, done_b}), 128'd0);

        // Auto-start full-rate pass on A; B must sit idle.
        rst_a = 1'b1; rst_b = 1'b1;
        @(posedge clk); #1;
        check_value("b_no_auto", 128'({we_b, busy_b}), 128'd0);
        sweep(1'b0, 3'b111, {2'b10, 2'b01, 2'b00}, 100, -1, 0, -1, -1, c);
        check_value("full_rate_cycles", 128'(c), 128'd256);
        check_value("b_still_idle", 128'({we_b, busy_b, done_b}), 128'd0);

        // Random ready, stall at 17, ignored mid-pass start.
        m = 3'($urandom_range(1, 7)); md = 6'($urandom);
        en_a = m; mode_a = md; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        sweep(1'b0, m, md, 70, 17, 5, 40, -1, c);

        // Reset mid-pass at address 100; auto-start restarts the sweep.
        m = 3'b111; md = 6'($urandom);
        en_a = m; mode_a = md; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        sweep(1'b0, m, md, 80, -1, 0, -1, 100, c);

        // All-zero mask; start coincides with final acceptance and is ignored.
        md = 6'($urandom);
        en_a = 3'b000; mode_a = md; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        sweep(1'b0, 3'b000, md, 60, -1, 0, 255, -1, c);
        @(posedge clk); #1;
        check_value("done_held", 128'({done_a, busy_a}), 128'b10);

        // B: start-only, single channel, narrow INDEX wraps every 16 entries.
        en_b = 3'b010; mode_b = 6'b01_01_01; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        sweep(1'b1, 3'b010, 6'b01_01_01, 75, -1, 0, 10, -1, c);

        // B: random modes at full rate.
        md = 6'($urandom);
        en_b = 3'b111; mode_b = md; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        sweep(1'b1, 3'b111, md, 100, -1, 0, -1, -1, c);
        check_value("b_full_rate_cycles", 128'(c), 128'd32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
